mesh_out_collector: RTL and testbench



---
 rtl/mesh_out_collector_if.sv | 28 ++
 rtl/mesh_out_collector.sv | 206 ++++++++++++++++++++
 tb/tb_mesh_out_collector.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mesh_out_collector_if.sv
// Bundle of mesh exit handshake, consumer valid/ready and status signals
// for mesh_out_collector. The collector uses the slave view; the mesh and
// result logic (or a bench) use the master view.
interface mesh_out_collector_if #(
    parameter int WIDTH     = 15,
    parameter int PKT_CNT_W = 16,
    parameter int ERR_CNT_W = 8
);
    logic                 o_req;
    logic [WIDTH-1:0]     o_data;
    logic                 o_ack;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_hop_err;
    logic [PKT_CNT_W-1:0] pkt_count;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  o_req, o_data, out_ready,
        output o_ack, out_valid, out_data, out_hop_err, pkt_count, err_count
    );

    modport master (
        output o_req, o_data, out_ready,
        input  o_ack, out_valid, out_data, out_hop_err, pkt_count, err_count
    );
endinterface

// File: rtl/mesh_out_collector.sv
// mesh_out_collector: clocked sink for the mesh exit channel O.
// Synchronizes the 4-phase request, pushes {data, hop_err} into a small
// circular FIFO, and presents the head through registered valid/ready
// outputs. Counts accepted and malformed packets with saturation.
module mesh_out_collector #(
    parameter int WIDTH       = 15,
    parameter int X_HOP_LOC   = 4,
    parameter int Y_HOP_LOC   = 7,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int PKT_CNT_W   = 16,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mesh_out_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        ACK_HI     = 2'd2
    } state_t;

    // A packet is malformed when any residual hop bit is still set.
    function automatic logic f_hop_err(input logic [WIDTH-1:0] data);
        return |data[Y_HOP_LOC:X_HOP_LOC];
    endfunction

    logic [1:0]             r_rst_sync;
    logic                   w_run;
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   w_req_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_ack;
    logic                   w_ack_nxt;
    logic                   w_push;
    logic                   w_push_hop;
    logic                   w_pop;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          w_rd_ptr_nxt;
    logic                   w_full;
    logic                   w_head_avail;
    logic [EW-1:0]          r_mem [DEPTH];
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_data;
    logic                   r_out_hop_err;
    logic [PKT_CNT_W-1:0]   r_pkt_count;
    logic [ERR_CNT_W-1:0]   r_err_count;

    assign w_req_s      = r_req_sync[SYNC_STAGES-1];
    assign w_run        = r_rst_sync[1];
    assign w_push_hop   = f_hop_err(bus.o_data);
    // Full is judged on registered pointers only, so a pop in this cycle
    // frees space for a push one cycle later.
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop        = r_out_valid & bus.out_ready;
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
    // Compare against the pre-push write pointer: a fresh entry reaches the
    // output registers one edge after it is written.
    assign w_head_avail = (w_rd_ptr_nxt != r_wr_ptr);

    assign bus.o_ack       = r_ack;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_hop_err = r_out_hop_err;
    assign bus.pkt_count   = r_pkt_count;
    assign bus.err_count   = r_err_count;

    // Reset release synchronizer: assert immediately, release after two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    // Request synchronizer chain for the asynchronous o_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_req_sync <= {SYNC_STAGES{1'b0}};
        else if (!w_run) r_req_sync <= {SYNC_STAGES{1'b0}};
        else             r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], bus.o_req};
    end

    // Handshake FSM next-state, acknowledge and push decision.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ack_nxt = 1'b0;
                if (w_req_s && !w_full) begin
                    w_push      = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ACK_HI;
                end else if (w_req_s) begin
                    w_state_nxt = WAIT_SPACE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_SPACE: begin
                w_ack_nxt = 1'b0;
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ACK_HI;
                end else begin
                    w_state_nxt = WAIT_SPACE;
                end
            end
            ACK_HI: begin
                if (!w_req_s) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ACK_HI;
                end
            end
            default: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and registered acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else if (!w_run) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {bus.o_data, w_push_hop};
    end

    // FIFO pointers with one wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
        end else if (!w_run) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
        end else begin
            r_wr_ptr <= w_push ? (r_wr_ptr + PW'(1'b1)) : r_wr_ptr;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Registered head presentation; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= {WIDTH{1'b0}};
            r_out_hop_err <= 1'b0;
        end else if (!w_run) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= {WIDTH{1'b0}};
            r_out_hop_err <= 1'b0;
        end else begin
            r_out_valid <= w_head_avail;
            if (w_head_avail) begin
                {r_out_data, r_out_hop_err} <= r_mem[w_rd_ptr_nxt[AW-1:0]];
            end else begin
                r_out_data    <= r_out_data;
                r_out_hop_err <= r_out_hop_err;
            end
        end
    end

    // Saturating packet and hop-error counters, updated on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count <= {PKT_CNT_W{1'b0}};
            r_err_count <= {ERR_CNT_W{1'b0}};
        end else if (!w_run) begin
            r_pkt_count <= {PKT_CNT_W{1'b0}};
            r_err_count <= {ERR_CNT_W{1'b0}};
        end else begin
            if (w_push && (r_pkt_count != {PKT_CNT_W{1'b1}}))
                r_pkt_count <= r_pkt_count + PKT_CNT_W'(1'b1);
            else
                r_pkt_count <= r_pkt_count;
            if (w_push && w_push_hop && (r_err_count != {ERR_CNT_W{1'b1}}))
                r_err_count <= r_err_count + ERR_CNT_W'(1'b1);
            else
                r_err_count <= r_err_count;
        end
    end
endmodule

// File: tb/tb_mesh_out_collector.sv
// Directed bench for mesh_out_collector: latency, hop-error table,
// backpressure, wrap-around streaming, mid-handshake reset, and counter
// saturation on a narrow-counter instance.
module tb_mesh_out_collector;
    localparam int W = 15;

    typedef struct {
        logic [W-1:0] data;
        logic         hop;
        logic [15:0]  pkt;
        logic [7:0]   err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rx;
    vec_t         vecs   [6];
    logic [W-1:0] wrap_d [12];
    logic [W-1:0] rx     [12];
    logic [W-1:0] bp_d   [5];

    always #5 clk = ~clk;

    mesh_out_collector_if #(.WIDTH(W), .PKT_CNT_W(16), .ERR_CNT_W(8)) bus ();
    mesh_out_collector_if #(.WIDTH(W), .PKT_CNT_W(3),  .ERR_CNT_W(2)) bus_s ();

    mesh_out_collector #(
        .WIDTH(W), .X_HOP_LOC(4), .Y_HOP_LOC(7), .SYNC_STAGES(2), .DEPTH(4),
        .PKT_CNT_W(16), .ERR_CNT_W(8)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    mesh_out_collector #(
        .WIDTH(W), .X_HOP_LOC(4), .Y_HOP_LOC(7), .SYNC_STAGES(2), .DEPTH(4),
        .PKT_CNT_W(3), .ERR_CNT_W(2)
    ) dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while ((bus.o_ack !== lvl) && (n < budget)) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.o_ack), 32'(lvl));
    endtask

    task automatic send_pkt(input logic [W-1:0] d, input string name);
        bus.o_data = d;
        bus.o_req  = 1'b1;
        wait_ack(1'b1, 12, {name, "_ack_hi"});
        bus.o_req  = 1'b0;
        wait_ack(1'b0, 12, {name, "_ack_lo"});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic consumer();
        int   cyc;
        logic rdy;
        cyc  = 0;
        rdy  = 1'b0;
        n_rx = 0;
        while ((n_rx < 12) && (cyc < 600)) begin
            rdy = ~rdy;
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                rx[n_rx] = bus.out_data;
                n_rx++;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.o_req       = 1'b0;
        bus.o_data      = 15'h0000;
        bus.out_ready   = 1'b0;
        bus_s.o_req     = 1'b0;
        bus_s.o_data    = 15'h0010;
        bus_s.out_ready = 1'b1;

        vecs[0] = '{15'h0090, 1'b1, 16'd1, 8'd1};
        vecs[1] = '{15'h4000, 1'b0, 16'd2, 8'd1};
        vecs[2] = '{15'h7A05, 1'b0, 16'd3, 8'd1};
        vecs[3] = '{15'h00F0, 1'b1, 16'd4, 8'd2};
        vecs[4] = '{15'h7F0F, 1'b0, 16'd5, 8'd2};
        vecs[5] = '{15'h0010, 1'b1, 16'd6, 8'd3};
        for (int i = 0; i < 12; i++) wrap_d[i] = 15'h1000 + 15'(i * 3);
        for (int i = 0; i < 5; i++) bp_d[i] = 15'(16'h0100 * (i + 1));

        // Reset state, sampled while reset is held.
        repeat (3) tick();
        chk("rst_ack",   32'(bus.o_ack),       32'h0);
        chk("rst_valid", 32'(bus.out_valid),   32'h0);
        chk("rst_data",  32'(bus.out_data),    32'h0);
        chk("rst_hop",   32'(bus.out_hop_err), 32'h0);
        chk("rst_pkt",   32'(bus.pkt_count),   32'h0);
        chk("rst_err",   32'(bus.err_count),   32'h0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Single packet latency.
        bus.out_ready = 1'b1;
        bus.o_data    = 15'h7A05;
        bus.o_req     = 1'b1;
        tick(); chk("lat_e1_ack", 32'(bus.o_ack), 32'h0);
        tick(); chk("lat_e2_ack", 32'(bus.o_ack), 32'h0);
        tick(); chk("lat_e3_ack", 32'(bus.o_ack), 32'h1);
        chk("lat_e3_pkt",   32'(bus.pkt_count), 32'h1);
        chk("lat_e3_valid", 32'(bus.out_valid), 32'h0);
        tick();
        chk("lat_e4_valid", 32'(bus.out_valid),   32'h1);
        chk("lat_e4_data",  32'(bus.out_data),    32'h7A05);
        chk("lat_e4_hop",   32'(bus.out_hop_err), 32'h0);
        bus.o_req = 1'b0;
        tick(); chk("fall_e1_ack", 32'(bus.o_ack), 32'h1);
        chk("fall_e1_valid", 32'(bus.out_valid), 32'h0);
        tick(); chk("fall_e2_ack", 32'(bus.o_ack), 32'h1);
        tick(); chk("fall_e3_ack", 32'(bus.o_ack), 32'h0);
        bus.out_ready = 1'b0;

        // Table: hop-field checking and cumulative counters.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_pkt(vecs[i].data, "tbl");
            chk("tbl_valid", 32'(bus.out_valid),   32'h1);
            chk("tbl_data",  32'(bus.out_data),    32'(vecs[i].data));
            chk("tbl_hop",   32'(bus.out_hop_err), 32'(vecs[i].hop));
            chk("tbl_pkt",   32'(bus.pkt_count),   32'(vecs[i].pkt));
            chk("tbl_err",   32'(bus.err_count),   32'(vecs[i].err));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            chk("tbl_popped", 32'(bus.out_valid), 32'h0);
        end

        // Backpressure: four fit, the fifth waits for space.
        do_reset();
        for (int i = 0; i < 4; i++) send_pkt(bp_d[i], "bp");
        bus.o_data = bp_d[4];
        bus.o_req  = 1'b1;
        repeat (10) tick();
        chk("bp_stall_ack",  32'(bus.o_ack),     32'h0);
        chk("bp_stall_pkt",  32'(bus.pkt_count), 32'd4);
        chk("bp_head_data",  32'(bus.out_data),  32'h0100);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_after_pop_data", 32'(bus.out_data), 32'h0200);
        wait_ack(1'b1, 2, "bp_fifth_ack");
        bus.o_req = 1'b0;
        wait_ack(1'b0, 12, "bp_fifth_ack_lo");
        chk("bp_pkt", 32'(bus.pkt_count), 32'd5);
        for (int i = 1; i < 5; i++) begin
            chk("bp_drain_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_drain_data",  32'(bus.out_data),  32'(bp_d[i]));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        chk("bp_drained", 32'(bus.out_valid), 32'h0);

        // Wrap-around streaming with a toggling consumer.
        do_reset();
        fork
            begin
                for (int i = 0; i < 12; i++) send_pkt(wrap_d[i], "wrap");
            end
            consumer();
        join
        chk("wrap_count", 32'(n_rx), 32'd12);
        for (int i = 0; i < 12; i++) chk("wrap_order", 32'(rx[i]), 32'(wrap_d[i]));
        chk("wrap_pkt", 32'(bus.pkt_count), 32'd12);

        // Reset while in ACK_HI with two entries queued.
        do_reset();
        send_pkt(15'h0111, "mid");
        bus.o_data = 15'h0222;
        bus.o_req  = 1'b1;
        wait_ack(1'b1, 12, "mid_ack_hi");
        chk("mid_pkt_pre", 32'(bus.pkt_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack",   32'(bus.o_ack),     32'h0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_pkt",   32'(bus.pkt_count), 32'h0);
        chk("mid_rst_err",   32'(bus.err_count), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_ack(1'b1, 20, "mid_reaccept_ack");
        chk("mid_reaccept_pkt", 32'(bus.pkt_count), 32'd1);
        tick();
        chk("mid_reaccept_valid", 32'(bus.out_valid), 32'h1);
        chk("mid_reaccept_data",  32'(bus.out_data),  32'h0222);
        bus.o_req = 1'b0;
        wait_ack(1'b0, 12, "mid_ack_lo");

        // Saturation on the narrow-counter instance (3-bit pkt, 2-bit err).
        for (int p = 1; p <= 9; p++) begin
            bus_s.o_req = 1'b1;
            repeat (2) tick();
            bus_s.o_req = 1'b0;
            repeat (2) tick();
            if ((p == 3) || (p == 7) || (p == 9)) begin
                repeat (4) tick();
                chk("sat_pkt", 32'(bus_s.pkt_count), 32'((p > 7) ? 7 : p));
                chk("sat_err", 32'(bus_s.err_count), 32'((p > 3) ? 3 : p));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
